// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock divider, h/v counters, registered
// sync/active-video decode, line/frame pulses and a completed-frame counter.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CLK_DIV  = 2,
  parameter int   CNT_W    = 10,
  parameter int   FRAME_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               pix_ce,
  output logic               vga_clk,
  output logic [CNT_W-1:0]   h_count,
  output logic [CNT_W-1:0]   v_count,
  output logic               hsync,
  output logic               vsync,
  output logic               display_area,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam bit CFG_OK  = ((H_TOTAL - 1) <= (2**CNT_W - 1)) &&
                           ((V_TOTAL - 1) <= (2**CNT_W - 1)) &&
                           (CLK_DIV >= 2) && (CLK_DIV <= 16);

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic               r_run;
  logic [DIV_W-1:0]   r_div;
  logic [CNT_W-1:0]   r_h;
  logic [CNT_W-1:0]   r_v;
  logic               r_pix_ce;
  logic               r_vga_clk;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_de;
  logic               r_ls;
  logic               r_fs;
  logic [FRAME_W-1:0] r_fc;

  logic [DIV_W-1:0]   w_div_n;
  logic [CNT_W-1:0]   w_h_n;
  logic [CNT_W-1:0]   w_v_n;
  logic               w_ce_n;

  // The first enabled cycle (r_run low) parks at (0,0) with divider 0, so the
  // first pixel strobe lands CLK_DIV clocks after enable or reset release.
  always_comb begin
    w_div_n = '0;
    w_h_n   = '0;
    w_v_n   = '0;
    if (en && r_run) begin
      w_h_n = r_h;
      w_v_n = r_v;
      if (r_div == DIV_MAX) begin
        if (r_h == H_LAST) begin
          w_h_n = '0;
          w_v_n = (r_v == V_LAST) ? '0 : r_v + CNT_W'(1);
        end else begin
          w_h_n = r_h + CNT_W'(1);
        end
      end else begin
        w_div_n = r_div + DIV_W'(1);
      end
    end
    w_ce_n = en && (w_div_n == DIV_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_run     <= 1'b0;
      r_div     <= '0;
      r_h       <= '0;
      r_v       <= '0;
      r_pix_ce  <= 1'b0;
      r_vga_clk <= 1'b0;
      r_hsync   <= ~HS_POL;
      r_vsync   <= ~VS_POL;
      r_de      <= 1'b0;
      r_ls      <= 1'b0;
      r_fs      <= 1'b0;
      r_fc      <= '0;
    end else begin
      if (r_fs) r_fc <= r_fc + FRAME_W'(1);
      r_run     <= en;
      r_div     <= w_div_n;
      r_h       <= w_h_n;
      r_v       <= w_v_n;
      r_pix_ce  <= w_ce_n;
      r_vga_clk <= en && (w_div_n >= DIV_HALF);
      r_hsync   <= (en && w_h_n >= HS_BEG && w_h_n < HS_END) ? HS_POL : ~HS_POL;
      r_vsync   <= (en && w_v_n >= VS_BEG && w_v_n < VS_END) ? VS_POL : ~VS_POL;
      r_de      <= en && (w_h_n < H_VIS) && (w_v_n < V_VIS);
      r_ls      <= w_ce_n && (w_h_n == H_LAST);
      r_fs      <= w_ce_n && (w_h_n == H_LAST) && (w_v_n == V_LAST);
    end
  end

  always_ff @(posedge clk) begin
    assert (CFG_OK)
      else $error("vga_timing_gen: totals exceed CNT_W range or CLK_DIV outside 2..16");
  end

  assign pix_ce       = r_pix_ce;
  assign vga_clk      = r_vga_clk;
  assign h_count      = r_h;
  assign v_count      = r_v;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign display_area = r_de;
  assign line_start   = r_ls;
  assign frame_start  = r_fs;
  assign frame_count  = r_fc;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 timing plus a tiny high-polarity
// configuration, compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;
  typedef struct {
    int div, ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
    bit hpol, vpol;
    int fw;
  } cfg_t;

  typedef struct {
    bit pix, vclk;
    int h, v;
    bit hs, vs, de, ls, fs;
    int fc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b0, en0 = 1'b0, rst1 = 1'b0, en1 = 1'b0;

  logic       pix0, vclk0, hs0, vs0, de0, ls0, fs0;
  logic [9:0] h0, v0;
  logic [7:0] fc0;
  logic       pix1, vclk1, hs1, vs1, de1, ls1, fs1;
  logic [9:0] h1, v1;
  logic [1:0] fc1;

  int n_checks = 0;
  int n_fail   = 0;

  cfg_t C0, C1;

  vga_timing_gen dut0 (
    .clk(clk), .rst(rst0), .en(en0), .pix_ce(pix0), .vga_clk(vclk0),
    .h_count(h0), .v_count(v0), .hsync(hs0), .vsync(vs0), .display_area(de0),
    .line_start(ls0), .frame_start(fs0), .frame_count(fc0)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(4), .CNT_W(10), .FRAME_W(2)
  ) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .pix_ce(pix1), .vga_clk(vclk1),
    .h_count(h1), .v_count(v1), .hsync(hs1), .vsync(vs1), .display_area(de1),
    .line_start(ls1), .frame_start(fs1), .frame_count(fc1)
  );

  logic [32:0] obs0, obs1;
  assign obs0 = {pix0, vclk0, h0, v0, hs0, vs0, de0, ls0, fs0, fc0};
  assign obs1 = {pix1, vclk1, h1, v1, hs1, vs1, de1, ls1, fs1, 6'b0, fc1};

  // Expected outputs t cycles after the first enabled cycle (t=0 shows (0,0)).
  function automatic exp_t model(input cfg_t c, input int t, input int fc_start);
    exp_t e;
    int ht, vt, p, d;
    ht     = c.ha + c.hfp + c.hsw + c.hbp;
    vt     = c.va + c.vfp + c.vsw + c.vbp;
    p      = t / c.div;
    d      = t % c.div;
    e.h    = p % ht;
    e.v    = (p / ht) % vt;
    e.pix  = (d == c.div - 1);
    e.vclk = (d >= c.div / 2);
    e.hs   = (e.h >= c.ha + c.hfp && e.h < c.ha + c.hfp + c.hsw) ? c.hpol : !c.hpol;
    e.vs   = (e.v >= c.va + c.vfp && e.v < c.va + c.vfp + c.vsw) ? c.vpol : !c.vpol;
    e.de   = (e.h < c.ha) && (e.v < c.va);
    e.ls   = e.pix && (e.h == ht - 1);
    e.fs   = e.ls && (e.v == vt - 1);
    e.fc   = (fc_start + t / (c.div * ht * vt)) % (1 << c.fw);
    return e;
  endfunction

  function automatic exp_t idle(input cfg_t c, input int fc);
    exp_t e;
    e.pix = 0; e.vclk = 0; e.h = 0; e.v = 0;
    e.hs = !c.hpol; e.vs = !c.vpol; e.de = 0; e.ls = 0; e.fs = 0;
    e.fc = fc;
    return e;
  endfunction

  function automatic logic [32:0] pack(input exp_t e);
    return {e.pix, e.vclk, 10'(e.h), 10'(e.v), e.hs, e.vs, e.de, e.ls, e.fs, 8'(e.fc)};
  endfunction

  task automatic test_reset;
    en0 = 1'b1; en1 = 1'b1; rst0 = 1'b0; rst1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs0 !== pack(idle(C0, 0))) begin
      n_fail++; $display("FAIL reset_dut0 got %h expected %h", obs0, pack(idle(C0, 0)));
    end
    n_checks++;
    if (obs1 !== pack(idle(C1, 0))) begin
      n_fail++; $display("FAIL reset_dut1 got %h expected %h", obs1, pack(idle(C1, 0)));
    end
  endtask

  task automatic test_default_lines;
    int hs_low, de_high, ls_first, ls_second;
    hs_low = 0; de_high = 0; ls_first = -1; ls_second = -1;
    rst0 = 1'b1;
    for (int t = 0; t < 5000; t++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (obs0 !== pack(model(C0, t, 0))) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL default_line t=%0d got %h expected %h", t, obs0, pack(model(C0, t, 0)));
      end
      if (t < 1600 && hs0 == 1'b0) hs_low++;
      if (t < 1600 && de0 == 1'b1) de_high++;
      if (ls0 && ls_first >= 0 && ls_second < 0) ls_second = t;
      if (ls0 && ls_first < 0) ls_first = t;
    end
    n_checks++;
    if (hs_low !== 192) begin n_fail++; $display("FAIL hsync_low_clks got %0d expected 192", hs_low); end
    n_checks++;
    if (de_high !== 1280) begin n_fail++; $display("FAIL display_clks got %0d expected 1280", de_high); end
    n_checks++;
    if (ls_second - ls_first !== 1600) begin
      n_fail++; $display("FAIL line_period got %0d expected 1600", ls_second - ls_first);
    end
  endtask

  task automatic test_reset_mid;
    int stop;
    stop = 2 * 1600 + 600 + int'($urandom_range(0, 1));
    rst0 = 1'b0;
    @(posedge clk); @(negedge clk);
    rst0 = 1'b1;
    for (int t = 0; t <= stop; t++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (obs0 !== pack(model(C0, t, 0))) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL pre_reset t=%0d got %h expected %h", t, obs0, pack(model(C0, t, 0)));
      end
    end
    rst0 = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (obs0 !== pack(idle(C0, 0))) begin
      n_fail++; $display("FAIL mid_reset got %h expected %h", obs0, pack(idle(C0, 0)));
    end
    rst0 = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (obs0 !== pack(model(C0, t, 0))) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL post_reset t=%0d got %h expected %h", t, obs0, pack(model(C0, t, 0)));
      end
    end
  endtask

  task automatic test_small_frames;
    int fc_at[5];
    int exp_fc[5] = '{1, 2, 3, 0, 1};
    int ls_cnt, fs_first;
    logic [3:0] vpat;
    ls_cnt = 0; fs_first = -1; vpat = '0;
    rst1 = 1'b1;
    for (int t = 0; t <= 5 * 392; t++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (obs1 !== pack(model(C1, t, 0))) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL small_frame t=%0d got %h expected %h", t, obs1, pack(model(C1, t, 0)));
      end
      if (t > 0 && t % 392 == 0) fc_at[t / 392 - 1] = int'(fc1);
      if (t < 392 && ls1) ls_cnt++;
      if (fs1 && fs_first < 0) fs_first = t;
      if (t < 4) vpat[3 - t] = vclk1;
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (fc_at[k] !== exp_fc[k]) begin
        n_fail++; $display("FAIL frame_count_seq idx=%0d got %0d expected %0d", k, fc_at[k], exp_fc[k]);
      end
    end
    n_checks++;
    if (ls_cnt !== 7) begin n_fail++; $display("FAIL lines_per_frame got %0d expected 7", ls_cnt); end
    n_checks++;
    if (fs_first !== 391) begin n_fail++; $display("FAIL first_frame_start got %0d expected 391", fs_first); end
    n_checks++;
    if (vpat !== 4'b0011) begin n_fail++; $display("FAIL vga_clk_pattern got %b expected 0011", vpat); end
  endtask

  task automatic test_en_drop;
    int t0, stop, held;
    exp_t last;
    t0   = 5 * 392 + 1;
    stop = t0 + int'($urandom_range(50, 380));
    for (int t = t0; t <= stop; t++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (obs1 !== pack(model(C1, t, 0))) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL pre_drop t=%0d got %h expected %h", t, obs1, pack(model(C1, t, 0)));
      end
    end
    last = model(C1, stop, 0);
    held = (last.fc + (last.fs ? 1 : 0)) % 4;
    en1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (obs1 !== pack(idle(C1, held))) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL en_low k=%0d got %h expected %h", k, obs1, pack(idle(C1, held)));
      end
    end
    en1 = 1'b1;
    for (int t = 0; t < 800; t++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (obs1 !== pack(model(C1, t, held))) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL en_restart t=%0d got %h expected %h", t, obs1, pack(model(C1, t, held)));
      end
    end
  endtask

  task automatic test_reset_frame;
    int stop;
    stop = int'($urandom_range(100, 390));
    for (int k = 0; k < stop; k++) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (obs1 !== pack(idle(C1, 0))) begin
      n_fail++; $display("FAIL frame_reset got %h expected %h", obs1, pack(idle(C1, 0)));
    end
    rst1 = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (obs1 !== pack(model(C1, t, 0))) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL after_frame_reset t=%0d got %h expected %h", t, obs1, pack(model(C1, t, 0)));
      end
    end
  endtask

  initial begin
    C0 = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8};
    C1 = '{4, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b0, 2};
    test_reset;
    test_default_lines;
    test_reset_mid;
    test_small_frames;
    test_en_drop;
    test_reset_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL accept parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL accept parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL accept parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL accept parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL accept parameters HS_POL/VS_POL, default 0/0, asserted sync level (0 = active-low).
REQ-006 SHALL accept parameter CLK_DIV, default 2, system clocks per pixel; legal range is 2..16.
REQ-007 SHALL accept parameters CNT_W, default 10, counter width; FRAME_W, default 8, frame counter width.
REQ-008 SHALL provide ports: clk  in  1  system clock.
REQ-009 rst  in  1  synchronous active-low reset.
REQ-010 en  in  1  timing run enable.
REQ-011 pix_ce  out  1  one-clk pixel strobe; vga_clk  out  1  divided pixel clock.
REQ-012 h_count, v_count  out  CNT_W  current pixel column and line.
REQ-013 hsync, vsync, display_area  out  1  sync outputs and active-video flag.
REQ-014 line_start, frame_start  out  1  one-clk pulses; frame_count  out  FRAME_W  completed-frame count.

Function
REQ-015 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP SHALL apply; a simulation-time check SHALL flag the configuration when H_TOTAL-1 or V_TOTAL-1 exceeds 2^CNT_W-1.
REQ-016 The divider counter SHALL count 0..CLK_DIV-1 and wrap; pix_ce SHALL be high exactly in the clk cycle where the divider equals CLK_DIV-1.
REQ-017 vga_clk SHALL be a registered output, high while the divider is >= CLK_DIV/2 (integer division), so counters change on the vga_clk falling edge.
REQ-018 On pix_ce, h_count SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and v_count SHALL increment; at v_count V_TOTAL-1 with the h wrap, v_count SHALL wrap to 0.
REQ-019 hsync SHALL equal HS_POL while H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC; otherwise it SHALL equal ~HS_POL.
REQ-020 vsync SHALL equal VS_POL while V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC, for whole lines; otherwise it SHALL equal ~VS_POL.
REQ-021 display_area SHALL be 1 iff h_count < H_ACTIVE and v_count < V_ACTIVE.
REQ-022 hsync, vsync and display_area SHALL be registered and decoded from next-state counts, so they are valid in the same cycle as the matching h_count/v_count with zero latency skew.
REQ-023 line_start SHALL pulse for one clk on each pix_ce that wraps h_count to 0; frame_start SHALL pulse on the pix_ce that wraps both counts to (0,0).
REQ-024 frame_count SHALL increment with each frame_start pulse and SHALL wrap modulo 2^FRAME_W.
REQ-025 With en=0: divider, h_count and v_count SHALL clear to 0 and hold; pix_ce, line_start, frame_start and display_area SHALL be 0; syncs SHALL be inactive; vga_clk SHALL be 0; frame_count SHALL hold.
REQ-026 After en rises, the first pix_ce SHALL occur CLK_DIV clks later, and display_area SHALL be 1 from the first en=1 cycle (count 0,0).
REQ-027 rst SHALL take priority over en.

Reset
REQ-028 On a clk edge with rst=0: divider, h_count, v_count and frame_count SHALL be 0; pix_ce, vga_clk, line_start, frame_start and display_area SHALL be 0; hsync SHALL be ~HS_POL and vsync SHALL be ~VS_POL.
REQ-029 Reset asserted mid-line or mid-frame SHALL abort the frame without a frame_start pulse; after release, timing SHALL behave as in REQ-026.

Verification
REQ-030 Defaults, en=1: hsync period SHALL be 1600 clk, low 192 clk from h_count 656 to 751; display_area SHALL be high 1280 clk per visible line.
REQ-031 Defaults: vsync SHALL be low for v_count 490-491 (3200 clk); frame_start period SHALL be 840000 clk; frame_count SHALL read 3 after 3 frames.
REQ-032 FRAME_W=2, run 5 frames -> frame_count sequence SHALL be 1,2,3,0,1.
REQ-033 Assert rst at h_count 300, v_count 200 for 1 clk -> all outputs SHALL match REQ-028 next cycle; first pix_ce SHALL come 2 clk after release; no frame_start SHALL be emitted.
REQ-034 Drop en at v_count 100 for 10 clk -> counters SHALL be 0 and syncs SHALL be inactive; frame_count SHALL be unchanged; timing SHALL restart from (0,0).
REQ-035 CLK_DIV=4, HS_POL=1, H 8/2/2/2, V 4/1/1/1 -> line SHALL be 56 clk; hsync SHALL be high for h_count 10-11; vga_clk SHALL have a 2-high/2-low pattern; frame SHALL be 392 clk.
